// File: rtl/uart_rx.sv
// UART receiver for 8N1/8P1 frames: oversampled start detection, 3-sample majority vote per bit,
// parity and stop checking, with one-cycle result pulses.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       Data_Valid,
  output logic       Par_Err,
  output logic       Stop_Err,
  output logic       Busy
);

  localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t CntLast = cnt_t'(OVERSAMPLE - 1);
  localparam cnt_t CntS0   = cnt_t'(OVERSAMPLE / 2 - 1);
  localparam cnt_t CntS1   = cnt_t'(OVERSAMPLE / 2);
  localparam cnt_t CntS2   = cnt_t'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e     state_q;
  logic [1:0] sync_q;
  cnt_t       edge_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [2:0] samp_q;
  logic [7:0] shift_q;
  logic       par_en_q;
  logic       par_typ_q;
  logic       par_bad_q;

  logic       rx_s;
  logic [2:0] samp_cur;
  logic       vote;
  logic       bit_done;
  logic       exp_par;

  assign rx_s     = sync_q[1];
  assign bit_done = (edge_cnt_q == CntLast);
  assign exp_par  = (^shift_q) ^ par_typ_q;

  // Fold this cycle's sample in so the vote is correct even when the last sample point
  // coincides with the decision count (OVERSAMPLE = 4).
  always_comb begin
    samp_cur = samp_q;
    if (edge_cnt_q == CntS0) samp_cur[0] = rx_s;
    if (edge_cnt_q == CntS1) samp_cur[1] = rx_s;
    if (edge_cnt_q == CntS2) samp_cur[2] = rx_s;
  end

  assign vote = (samp_cur[0] & samp_cur[1]) | (samp_cur[0] & samp_cur[2]) |
                (samp_cur[1] & samp_cur[2]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      sync_q     <= 2'b11;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= 3'b111;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], RX_IN};
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;

      if (state_q != StIdle) begin
        samp_q     <= samp_cur;
        edge_cnt_q <= bit_done ? '0 : edge_cnt_q + cnt_t'(1);
      end

      case (state_q)
        StIdle: begin
          edge_cnt_q <= '0;
          bit_cnt_q  <= '0;
          // The detection cycle itself is count 0 of the start bit.
          if (!rx_s) begin
            state_q    <= StStart;
            edge_cnt_q <= cnt_t'(1);
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            par_bad_q  <= 1'b0;
            Busy       <= 1'b1;
          end
        end

        StStart: begin
          if (bit_done) begin
            if (vote) begin
              state_q <= StIdle;
              Busy    <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end
        end

        StData: begin
          if (bit_done) begin
            shift_q   <= {vote, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= par_en_q ? StParity : StStop;
            end
          end
        end

        StParity: begin
          if (bit_done) begin
            par_bad_q <= (vote != exp_par);
            state_q   <= StStop;
          end
        end

        StStop: begin
          if (bit_done) begin
            state_q <= StIdle;
            Busy    <= 1'b0;
            if (vote && !par_bad_q) begin
              P_DATA     <= shift_q;
              Data_Valid <= 1'b1;
            end else if (vote) begin
              Par_Err <= 1'b1;
            end else begin
              Stop_Err <= 1'b1;
              Par_Err  <= par_bad_q;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model predicts every output per cycle from bit timing rules.
module tb_uart_rx;

  localparam int unsigned OS   = 8;
  localparam int          MAXC = 30000;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stop_Err;
  logic       Busy;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .Par_Err   (Par_Err),
    .Stop_Err  (Stop_Err),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected outputs indexed by the edge after which they are observed.
  bit         exp_dv   [MAXC];
  bit         exp_pe   [MAXC];
  bit         exp_se   [MAXC];
  bit         exp_busy [MAXC];
  bit         exp_pdu  [MAXC];
  logic [7:0] exp_pdv  [MAXC];
  logic [7:0] cur_pd = 8'h00;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int last_dv = -1;
  int prev_dv = -1;
  int last_pe = -1;
  int last_se = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_from(input int k0);
    for (int k = k0; k < k0 + 300 && k < MAXC; k++) begin
      exp_dv[k] = 0; exp_pe[k] = 0; exp_se[k] = 0; exp_busy[k] = 0; exp_pdu[k] = 0;
    end
  endtask

  // Drives a frame starting at the next edge (edge 0); nbits < frame length aborts early.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic bad_par, input logic stop_v, input bit flip,
                            input int nbits, output int e0);
    int          f, nb, r;
    logic        par;
    logic [10:0] fr;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    e0  = cyc + 1;
    nb  = pen ? 11 : 10;
    f   = nb * OS;
    par = (^d) ^ ptyp ^ bad_par;
    fr  = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    if (pen) begin
      fr[9]  = par;
      fr[10] = stop_v;
    end else begin
      fr[9] = stop_v;
    end
    for (int k = e0 + 2; k <= e0 + f; k++) exp_busy[k] = 1;
    r = e0 + f + 1;
    if (stop_v && !(pen && bad_par)) begin
      exp_dv[r] = 1; exp_pdu[r] = 1; exp_pdv[r] = d;
    end else if (stop_v) begin
      exp_pe[r] = 1;
    end else begin
      exp_se[r] = 1;
      exp_pe[r] = pen && bad_par;
    end
    for (int i = 0; i < nb && i < nbits; i++) begin
      RX_IN = fr[i];
      repeat (OS) @(posedge CLK);
      #1;
      if (flip && i == 0) begin
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
      end
    end
  endtask

  task automatic glitch(input int g);
    int e0;
    e0 = cyc + 1;
    for (int k = e0 + 2; k <= e0 + OS; k++) exp_busy[k] = 1;
    RX_IN = 1'b0;
    repeat (g) @(posedge CLK);
    #1;
    idle(OS + 4);
  endtask

  task automatic do_reset(input logic line);
    RST   = 1'b0;
    RX_IN = line;
    #1;
    clear_from(cyc);
    exp_pdu[cyc] = 1;
    exp_pdv[cyc] = 8'h00;
    chk("rst_pdata", {24'h0, P_DATA}, 32'h0);
    chk("rst_flags", {28'h0, Data_Valid, Par_Err, Stop_Err, Busy}, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    fork
      begin : stim
        int e0, dv0, pe0;
        repeat (3) @(posedge CLK);
        #1;
        chk("init_pdata", {24'h0, P_DATA}, 32'h0);
        chk("init_flags", {28'h0, Data_Valid, Par_Err, Stop_Err, Busy}, 32'h0);
        RST = 1'b1;
        idle(4);
        mon_en = 1'b1;

        send_frame(8'hBB, 0, 0, 0, 1, 0, 99, e0);
        idle(4);
        chk("bb_dv_edge", last_dv - e0, 81);
        chk("bb_pdata", {24'h0, P_DATA}, 32'hBB);

        send_frame(8'h3B, 1, 0, 0, 1, 0, 99, e0);
        idle(4);
        chk("3b_dv_edge", last_dv - e0, 89);
        dv0 = last_dv;
        send_frame(8'h3B, 1, 0, 1, 1, 0, 99, e0);
        idle(4);
        chk("3b_pe_edge", last_pe - e0, 89);
        chk("3b_no_dv", last_dv, dv0);
        chk("3b_hold", {24'h0, P_DATA}, 32'h3B);

        send_frame(8'h8E, 1, 1, 0, 1, 0, 99, e0);
        idle(4);
        chk("8e_pdata", {24'h0, P_DATA}, 32'h8E);

        dv0 = last_dv;
        send_frame(8'h1D, 0, 0, 0, 0, 0, 99, e0);
        idle(4);
        chk("1d_se_edge", last_se - e0, 81);
        chk("1d_no_dv", last_dv, dv0);
        chk("1d_idle", {31'h0, Busy}, 32'h0);

        dv0 = last_dv;
        pe0 = last_pe;
        glitch(3);
        chk("gl_busy", {31'h0, Busy}, 32'h0);
        chk("gl_no_dv", last_dv, dv0);
        chk("gl_no_pe", last_pe, pe0);
        send_frame(8'h55, 0, 0, 0, 1, 0, 99, e0);
        idle(4);
        chk("55_pdata", {24'h0, P_DATA}, 32'h55);

        send_frame(8'hA5, 0, 0, 0, 1, 0, 99, e0);
        send_frame(8'h5A, 0, 0, 0, 1, 0, 99, e0);
        idle(4);
        chk("b2b_gap", last_dv - prev_dv, 80);
        chk("b2b_pdata", {24'h0, P_DATA}, 32'h5A);

        send_frame(8'hC3, 0, 0, 0, 1, 0, 4, e0);
        do_reset(1'b0);
        send_frame(8'h96, 0, 0, 0, 1, 0, 99, e0);
        idle(4);
        chk("post_rst_pdata", {24'h0, P_DATA}, 32'h96);
        chk("post_rst_edge", last_dv - e0, 81);

        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 9) == 0) begin
            glitch(int'($urandom_range(1, OS / 2 - 1)));
          end else begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 4) != 0, 1, 99, e0);
            if ($urandom_range(0, 3) != 0) idle(int'($urandom_range(1, 2 * OS)));
          end
        end
        idle(OS * 3);
      end
      begin : mon
        forever begin
          @(negedge CLK);
          if (cyc < MAXC) begin
            if (exp_pdu[cyc]) cur_pd = exp_pdv[cyc];
            if (mon_en) begin
              chk("flags dv/pe/se/busy", {28'h0, Data_Valid, Par_Err, Stop_Err, Busy},
                  {28'h0, exp_dv[cyc], exp_pe[cyc], exp_se[cyc], exp_busy[cyc]});
              chk("p_data", {24'h0, P_DATA}, {24'h0, cur_pd});
            end
          end
          if (Data_Valid === 1'b1) begin
            prev_dv = last_dv;
            last_dv = cyc;
          end
          if (Par_Err === 1'b1) last_pe = cyc;
          if (Stop_Err === 1'b1) last_se = cyc;
        end
      end
      begin : watchdog
        #(10 * (MAXC - 100));
        errors++;
        $display("FAIL timeout cyc=%0d got=running want=done", cyc);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: the counterpart of the UART transmitter top, using the same 8N1/8P1 frame. It oversamples RX_IN, finds the start bit, majority-votes each bit, checks parity and stop, and presents the byte on P_DATA with a one-cycle Data_Valid pulse. It sits between the pad-side serial line and the parallel consumer. PAR_EN/PAR_TYP semantics match the transmitter's configuration ports.

## Interface
- OVERSAMPLE, 8: clocks per bit; legal values are even numbers from 4 to 32.
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line; idles high; asynchronous to CLK.
- PAR_EN  in  1  1 = frame carries a parity bit between D7 and stop.
- PAR_TYP  in  1  0 = even parity (parity bit = XOR of D7..D0); 1 = odd parity (parity bit = XNOR of D7..D0).
- P_DATA  out  8  last received byte, LSB first on the line; held until the next accepted frame.
- Data_Valid  out  1  one-cycle pulse: a good frame was received.
- Par_Err  out  1  one-cycle pulse: parity mismatch.
- Stop_Err  out  1  one-cycle pulse: stop bit sampled 0.
- Busy  out  1  high while the FSM is not IDLE.

## Operation
- Synchronizer: 2 flops on RX_IN, both reset to 1. rx_s is the synchronized value. All decisions use rx_s.
- Bit timing: edge_cnt runs 0..OVERSAMPLE-1 per bit. At edge_cnt = OS/2-1, OS/2 and OS/2+1, rx_s is sampled. The bit value is the majority of these 3 samples. Decisions are taken at edge_cnt = OS-1.
- bit_cnt 0..7 indexes data bits. Data is shifted in LSB first.
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE:
  - If rx_s=0, this cycle is count 0 of the start bit.
  - Go to START with edge_cnt=1.
  - Latch PAR_EN and PAR_TYP at this point; later changes to these inputs are ignored until the next frame.
- START: at OS-1, a majority of 0 goes to DATA. A majority of 1 is a glitch: return to IDLE with no output pulse.
- DATA: at OS-1, store the bit. After bit_cnt=7, go to PARITY if parity is latched enabled, else go to STOP.
- PARITY: at OS-1, compare the sampled bit with the bit computed from the received byte under the latched PAR_TYP, and record the mismatch flag. Go to STOP.
- STOP: at OS-1, return to IDLE and drive exactly one output pulse on that edge:
  - stop=1 and parity OK: P_DATA updated and Data_Valid pulses.
  - stop=1 and parity bad: Par_Err pulses; P_DATA unchanged.
  - stop=0: Stop_Err pulses, plus Par_Err if parity was also bad; P_DATA unchanged; Data_Valid stays 0.
- Back-to-back frames: IDLE is re-entered in time to detect a start bit whose count 0 is the cycle right after the stop bit ends. No idle gap is required.
- Reset, at power-up or mid-frame, takes effect immediately:
  - FSM goes to IDLE and all counters clear.
  - P_DATA=0x00; Data_Valid, Par_Err, Stop_Err and Busy = 0; synchronizer flops = 1.
  - A partial frame is discarded. After release, a line still low is treated as a new start edge.

## Timing
- Frame length F = OS×10 clocks (no parity) or OS×11 clocks (parity).
- Take edge 0 as the rising edge at which RX_IN is first sampled 0.
  - Busy rises after edge 2.
  - The result pulse (Data_Valid, Par_Err or Stop_Err) is high after edge F+1, for exactly one cycle.
  - Busy falls on the same edge F+1.
- Data_Valid, Par_Err and Stop_Err are registered and never high across two consecutive cycles for one frame.
- The receiver tolerates the accumulated sampling-phase error of the 3-sample vote; the line rate must equal CLK/OVERSAMPLE.

## Test plan
- OS=8, PAR_EN=0, drive 0xBB LSB first at 8 clk/bit → P_DATA=0xBB and Data_Valid for 1 cycle at edge 81; Par_Err=Stop_Err=0; Busy high from edge 2 to edge 81.
- PAR_EN=1, PAR_TYP=0, byte 0x3B with parity bit 1 → Data_Valid at edge 89. Then the same byte with parity bit 0 → Par_Err pulse, no Data_Valid, P_DATA stays 0x3B.
- PAR_EN=1, PAR_TYP=1, byte 0x8E with parity bit 1 → Data_Valid, P_DATA=0x8E.
- Stop bit forced 0 on 0x1D → Stop_Err pulse, Data_Valid=0, FSM back in IDLE.
- Start glitch: RX_IN low for 3 clocks, then high → no pulse, Busy drops back at the OS-1 decision, and a following valid 0x55 is received correctly.
- Two back-to-back frames 0xA5, 0x5A with no gap → two Data_Valid pulses exactly F clocks apart. Assert RST low mid-data → all outputs 0 at once, and the next full frame is received correctly.
